map_vrc4_core: RTL and testbench
================================

# map_vrc4_core

Parametrised VRC2/VRC4-class mapper core for the mapper tree. It extends the fixed 4-bit PRG / 5-bit CHR VRC1 scheme in four ways:
- generic bank widths;
- eight 1 KB CHR slots written as nibble pairs;
- PRG swap mode;
- a cycle/scanline IRQ counter with prescaler.

It sits between the CPU/PPU bus decode and the PRG/CHR/CIRAM address outputs. Board-specific wrappers tie off the address-line parameters.

## Interface
Parameters:
- PRG_BANK_W, 5, PRG bank register width (8 KB banks)
- CHR_BANK_W, 9, CHR bank register width (1 KB banks); low nibble plus (CHR_BANK_W-4)-bit high part
- A0_BIT, 0, cpu_addr bit used as register sub-select bit 0
- A1_BIT, 1, cpu_addr bit used as register sub-select bit 1
- IRQ_EN, 1, 0 removes the IRQ timer; irq is tied 0 and $F00x writes are ignored

Ports:
- m2  in  1  CPU M2; all state updates on falling edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_dat  in  8  CPU write data
- cpu_rw  in  1  1 = read
- ppu_addr  in  14  PPU address
- ss_act  in  1  save-state access active
- ss_we  in  1  save-state write strobe
- ss_addr  in  8  save-state register index
- ss_rdat  out  8  save-state readback
- prg_addr  out  PRG_BANK_W+13  ROM address
- chr_addr  out  CHR_BANK_W+10  CHR address
- ciram_a10  out  1  nametable select
- ram_ce  out  1  WRAM select, $6000-$7FFF
- irq  out  1  active-high IRQ request

## Operation
- Register write: falling m2 with !cpu_rw and cpu_addr[15] set, and ss_act low.
- Register select is {cpu_addr[14:12], cpu_addr[A1_BIT], cpu_addr[A0_BIT]}.
- Register map:
  - $8000-$8003: PRG0.
  - $9000: mirror[1:0]. 0 = V (ppu_addr[10]), 1 = H (ppu_addr[11]), 2 = one-screen 0, 3 = one-screen 1.
  - $9002: bit0 wram_en, bit1 prg_swap.
  - $A000-$A003: PRG1.
  - $B000-$E003: CHR slots 0-7. Slot n = 2·(page-$B) + sel[1]. sel[0] = 0 writes the low nibble (cpu_dat[3:0]); sel[0] = 1 writes the high part (cpu_dat[CHR_BANK_W-5:0]).
  - $F000 / $F001: latch low / high nibble.
  - $F002: ctrl[2:0] = {M, E, A}.
  - $F003: ack.
- PRG, 8 KB windows. prg_swap = 0: $8000 = PRG0, $A000 = PRG1, $C000 = all-ones minus 1, $E000 = all-ones. prg_swap = 1: $8000 and $C000 are exchanged.
- CHR: chr_addr = {chr[ppu_addr[12:10]], ppu_addr[9:0]}.
- ram_ce = wram_en & cpu_addr[15:13] == 3'b011.
- IRQ timer:
  - Prescaler starts at 341 and decrements by 3 each m2 while E = 1. When the result would be ≤ 0, add 338 and tick.
  - M = 1: tick every m2 instead.
  - Tick: if counter == 8'hFF, counter <= latch and irq <= 1; else counter + 1.
  - $F002 write: ctrl <= data; irq <= 0; prescaler <= 341; if new E, counter <= latch.
  - $F003 write: irq <= 0; E <= A.
- Save state:
  - ss_act = 1 blocks CPU writes.
  - ss_we writes index ss_addr from cpu_dat. Indices:
    - 0: PRG0
    - 1: PRG1
    - 2: {prg_swap, wram_en, mirror}
    - 3-10: chr low byte
    - 11-18: chr high
    - 19: latch
    - 20: counter
    - 21: ctrl
    - 22: prescaler[7:0]
    - 23: {irq, prescaler[8]}
  - ss_rdat is combinational; 8'hFF for unused indices.

## Timing
- Reset (asynchronous, rst_n low): all bank, mirror, swap, wram_en, latch, counter and ctrl registers 0; prescaler 341; irq 0. Outputs settle combinationally from these values: prg_addr high bits = PRG0 = 0 at $8000, ciram_a10 = ppu_addr[10].
- Register writes are visible on address outputs immediately after the write's falling edge; there is no pipelining.
- irq rises on the falling edge of the overflowing tick and holds until a $F002/$F003 write, a save-state write, or reset.
- Simultaneous events:
  - $F002 write and a tick on the same edge: the write wins; no overflow.
  - $F003 ack and an overflow on the same edge: irq stays 1.
  - Latch write on an overflow edge: the reload uses the old latch.
- Reset mid-count: immediate clear; no pending irq survives.

## Structure
- vrc_pkg holds:
  - register select codes;
  - mirror enum (MIR_V, MIR_H, MIR_S0, MIR_S1);
  - PRESCALE_INIT = 341, PRESCALE_STEP = 3;
  - save-state index constants.
- One sub-module, vrc_irq_timer: latch, counter, prescaler, ctrl, irq, with its own save-state ports. Generated only when IRQ_EN = 1.

## Test plan
- Reset, then read $E000 and $8000: prg_addr banks = 31 and 0; irq = 0; ciram_a10 tracks ppu_addr[10].
- Write $8000 = 5, $9002 = 2: $C000 maps to bank 5 and $8000 to bank 30; $A000 is unchanged.
- Write $B000 = $7 and $B001 = $1F (9-bit): ppu $0000 gives chr_addr bank 0x1F7. Write $B002: slot 1 changes and slot 0 is unchanged.
- Cycle mode: latch = $FD, $F002 = 6. irq rises on the 3rd falling m2 after the write; counter then reads $FD. $F003 with A = 0 clears irq and stops counting.
- Scanline mode: latch = $FF, $F002 = 2. First irq after 114 m2 edges (341/3 wrap), then every 113-114 edges, averaging 113.667.
- Save state: write indices 0-23 with distinct values via ss_we; ss_rdat returns each. A CPU write during ss_act leaves all registers unchanged.

Source files
------------

// File: rtl/vrc_pkg.sv
// Shared constants for the VRC2/VRC4-class mapper core: register decode codes,
// mirroring modes, IRQ prescaler constants and save-state register indices.
package vrc_pkg;

    typedef enum logic [1:0] {
        MIR_V  = 2'd0,
        MIR_H  = 2'd1,
        MIR_S0 = 2'd2,
        MIR_S1 = 2'd3
    } mirror_t;

    // Register page is cpu_addr[14:12]; sub-select is {A1, A0}.
    localparam logic [2:0] PAGE_PRG0 = 3'd0;
    localparam logic [2:0] PAGE_CTRL = 3'd1;
    localparam logic [2:0] PAGE_PRG1 = 3'd2;
    localparam logic [2:0] PAGE_IRQ  = 3'd7;

    localparam logic [1:0] SEL_MIRROR   = 2'd0;
    localparam logic [1:0] SEL_MISC     = 2'd2;
    localparam logic [1:0] SEL_LATCH_LO = 2'd0;
    localparam logic [1:0] SEL_LATCH_HI = 2'd1;
    localparam logic [1:0] SEL_IRQ_CTRL = 2'd2;
    localparam logic [1:0] SEL_IRQ_ACK  = 2'd3;

    localparam logic [8:0] PRESCALE_INIT   = 9'd341;
    localparam logic [8:0] PRESCALE_STEP   = 9'd3;
    localparam logic [8:0] PRESCALE_RELOAD = PRESCALE_INIT - PRESCALE_STEP;

    localparam logic [7:0] SS_PRG0     = 8'd0;
    localparam logic [7:0] SS_PRG1     = 8'd1;
    localparam logic [7:0] SS_MISC     = 8'd2;
    localparam logic [7:0] SS_CHR_LO   = 8'd3;
    localparam logic [7:0] SS_CHR_HI   = 8'd11;
    localparam logic [7:0] SS_CHR_END  = 8'd18;
    localparam logic [7:0] SS_LATCH    = 8'd19;
    localparam logic [7:0] SS_COUNTER  = 8'd20;
    localparam logic [7:0] SS_CTRL     = 8'd21;
    localparam logic [7:0] SS_PRESC_LO = 8'd22;
    localparam logic [7:0] SS_PRESC_HI = 8'd23;

    function automatic logic mirror_a10(input mirror_t mode, input logic [13:0] ppu_addr);
        case (mode)
            MIR_V:   return ppu_addr[10];
            MIR_H:   return ppu_addr[11];
            MIR_S0:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/vrc_irq_timer.sv
// VRC4 IRQ timer: 8-bit up-counter with reload latch, driven either every M2
// (cycle mode) or through the 341/3 prescaler that approximates PPU scanlines.
module vrc_irq_timer
    import vrc_pkg::*;
(
    input  logic       m2,
    input  logic       rst_n,
    input  logic       run,
    input  logic       wr_en,
    input  logic [1:0] sel,
    input  logic [7:0] dat,
    input  logic       ss_we,
    input  logic [7:0] ss_addr,
    output logic [7:0] ss_rdat,
    output logic       irq
);

    logic [7:0] latch;
    logic [7:0] counter;
    logic [2:0] ctrl;
    logic [8:0] prescaler;
    logic       presc_wrap;
    logic       tick;
    logic       overflow;
    logic       ack;

    // ctrl = {M, E, A}
    assign presc_wrap = (prescaler <= PRESCALE_STEP);
    assign tick       = run & ctrl[1] & (ctrl[2] | presc_wrap);
    assign overflow   = tick & (counter == 8'hFF);
    assign ack        = wr_en & (sel == SEL_IRQ_ACK);

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            latch     <= 8'h00;
            counter   <= 8'h00;
            ctrl      <= 3'b000;
            prescaler <= PRESCALE_INIT;
            irq       <= 1'b0;
        end else if (ss_we) begin
            case (ss_addr)
                SS_LATCH:    latch <= dat;
                SS_COUNTER:  counter <= dat;
                SS_CTRL:     ctrl <= dat[2:0];
                SS_PRESC_LO: prescaler[7:0] <= dat;
                SS_PRESC_HI: begin
                    prescaler[8] <= dat[0];
                    irq          <= dat[1];
                end
                default: ;
            endcase
        end else if (wr_en && sel == SEL_IRQ_CTRL) begin
            // A control write overrides any tick landing on the same edge.
            ctrl      <= dat[2:0];
            irq       <= 1'b0;
            prescaler <= PRESCALE_INIT;
            if (dat[1])
                counter <= latch;
        end else begin
            if (wr_en && sel == SEL_LATCH_LO)
                latch[3:0] <= dat[3:0];
            if (wr_en && sel == SEL_LATCH_HI)
                latch[7:4] <= dat[3:0];
            if (run && ctrl[1] && !ctrl[2])
                prescaler <= presc_wrap ? prescaler + PRESCALE_RELOAD : prescaler - PRESCALE_STEP;
            if (tick)
                counter <= overflow ? latch : counter + 8'd1;
            if (ack)
                ctrl[1] <= ctrl[0];
            irq <= overflow | (irq & ~ack);
        end
    end

    always_comb begin
        ss_rdat = 8'hFF;
        case (ss_addr)
            SS_LATCH:    ss_rdat = latch;
            SS_COUNTER:  ss_rdat = counter;
            SS_CTRL:     ss_rdat = {5'b00000, ctrl};
            SS_PRESC_LO: ss_rdat = prescaler[7:0];
            SS_PRESC_HI: ss_rdat = {6'b000000, irq, prescaler[8]};
            default:     ss_rdat = 8'hFF;
        endcase
    end

endmodule

// File: rtl/map_vrc4_core.sv
// Parametrised VRC2/VRC4-class mapper: PRG/CHR banking, mirroring, WRAM enable,
// optional IRQ timer and a save-state register port; all state moves on falling M2.
module map_vrc4_core
    import vrc_pkg::*;
#(
    parameter int PRG_BANK_W = 5,
    parameter int CHR_BANK_W = 9,
    parameter int A0_BIT     = 0,
    parameter int A1_BIT     = 1,
    parameter int IRQ_EN     = 1
) (
    input  logic                    m2,
    input  logic                    rst_n,
    input  logic [15:0]             cpu_addr,
    input  logic [7:0]              cpu_dat,
    input  logic                    cpu_rw,
    input  logic [13:0]             ppu_addr,
    input  logic                    ss_act,
    input  logic                    ss_we,
    input  logic [7:0]              ss_addr,
    output logic [7:0]              ss_rdat,
    output logic [PRG_BANK_W+12:0]  prg_addr,
    output logic [CHR_BANK_W+9:0]   chr_addr,
    output logic                    ciram_a10,
    output logic                    ram_ce,
    output logic                    irq
);

    localparam logic [PRG_BANK_W-1:0] PRG_LAST   = '1;
    localparam logic [PRG_BANK_W-1:0] PRG_SECOND = {{(PRG_BANK_W-1){1'b1}}, 1'b0};

    logic [PRG_BANK_W-1:0] prg0;
    logic [PRG_BANK_W-1:0] prg1;
    mirror_t               mirror;
    logic                  wram_en;
    logic                  prg_swap;
    logic [CHR_BANK_W-1:0] chr [8];

    logic [2:0] page;
    logic [1:0] sel;
    logic [1:0] chr_pair;
    logic [2:0] chr_slot;
    logic       cpu_wr;
    logic       ss_wr;
    logic       tm_wr;
    logic       ss_is_chr;
    logic       ss_chr_hi;
    logic [2:0] ss_chr_idx;
    logic [15:0] ss_chr_wide;
    logic [7:0] tm_rdat;
    logic [PRG_BANK_W-1:0] prg_bank;
    logic       unused_ppu;

    assign page     = cpu_addr[14:12];
    assign sel      = {cpu_addr[A1_BIT], cpu_addr[A0_BIT]};
    assign chr_pair = page[1:0] - 2'd3;
    assign chr_slot = {chr_pair, sel[1]};
    assign cpu_wr   = ~cpu_rw & cpu_addr[15] & ~ss_act;
    assign ss_wr    = ss_act & ss_we;
    assign tm_wr    = cpu_wr & (page == PAGE_IRQ);

    assign ss_is_chr   = (ss_addr >= SS_CHR_LO) && (ss_addr <= SS_CHR_END);
    assign ss_chr_hi   = (ss_addr >= SS_CHR_HI);
    assign ss_chr_idx  = ss_chr_hi ? 3'(ss_addr - SS_CHR_HI) : 3'(ss_addr - SS_CHR_LO);
    assign ss_chr_wide = 16'(chr[ss_chr_idx]);
    assign unused_ppu  = ppu_addr[13];

    // Save-state views a CHR bank as a zero-extended 16-bit value split in bytes.
    function automatic logic [CHR_BANK_W-1:0] put_byte(input logic [CHR_BANK_W-1:0] cur,
                                                       input logic hi, input logic [7:0] b);
        logic [15:0] w;
        w = 16'(cur);
        if (hi)
            w[15:8] = b;
        else
            w[7:0] = b;
        return w[CHR_BANK_W-1:0];
    endfunction

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            prg0     <= '0;
            prg1     <= '0;
            mirror   <= MIR_V;
            wram_en  <= 1'b0;
            prg_swap <= 1'b0;
            for (int i = 0; i < 8; i++)
                chr[i] <= '0;
        end else if (ss_wr) begin
            if (ss_addr == SS_PRG0)
                prg0 <= cpu_dat[PRG_BANK_W-1:0];
            if (ss_addr == SS_PRG1)
                prg1 <= cpu_dat[PRG_BANK_W-1:0];
            if (ss_addr == SS_MISC) begin
                mirror   <= mirror_t'(cpu_dat[1:0]);
                wram_en  <= cpu_dat[2];
                prg_swap <= cpu_dat[3];
            end
            if (ss_is_chr)
                chr[ss_chr_idx] <= put_byte(chr[ss_chr_idx], ss_chr_hi, cpu_dat);
        end else if (cpu_wr) begin
            case (page)
                PAGE_PRG0: prg0 <= cpu_dat[PRG_BANK_W-1:0];
                PAGE_PRG1: prg1 <= cpu_dat[PRG_BANK_W-1:0];
                PAGE_CTRL: begin
                    if (sel == SEL_MIRROR)
                        mirror <= mirror_t'(cpu_dat[1:0]);
                    if (sel == SEL_MISC) begin
                        wram_en  <= cpu_dat[0];
                        prg_swap <= cpu_dat[1];
                    end
                end
                3'd3, 3'd4, 3'd5, 3'd6: begin
                    if (sel[0])
                        chr[chr_slot][CHR_BANK_W-1:4] <= cpu_dat[CHR_BANK_W-5:0];
                    else
                        chr[chr_slot][3:0] <= cpu_dat[3:0];
                end
                default: ;
            endcase
        end
    end

    // Swap mode exchanges the $8000 and $C000 windows.
    always_comb begin
        prg_bank = PRG_LAST;
        case (cpu_addr[14:13])
            2'd0:    prg_bank = prg_swap ? PRG_SECOND : prg0;
            2'd1:    prg_bank = prg1;
            2'd2:    prg_bank = prg_swap ? prg0 : PRG_SECOND;
            default: prg_bank = PRG_LAST;
        endcase
    end

    assign prg_addr  = {prg_bank, cpu_addr[12:0]};
    assign chr_addr  = {chr[ppu_addr[12:10]], ppu_addr[9:0]};
    assign ciram_a10 = mirror_a10(mirror, ppu_addr);
    assign ram_ce    = wram_en & (cpu_addr[15:13] == 3'b011);

    generate
        if (IRQ_EN != 0) begin : g_irq
            vrc_irq_timer u_timer (
                .m2      (m2),
                .rst_n   (rst_n),
                .run     (~ss_act),
                .wr_en   (tm_wr),
                .sel     (sel),
                .dat     (cpu_dat),
                .ss_we   (ss_wr),
                .ss_addr (ss_addr),
                .ss_rdat (tm_rdat),
                .irq     (irq)
            );
        end else begin : g_no_irq
            assign tm_rdat = 8'hFF;
            assign irq     = 1'b0;
        end
    endgenerate

    always_comb begin
        ss_rdat = 8'hFF;
        if (ss_addr == SS_PRG0)
            ss_rdat = 8'(prg0);
        else if (ss_addr == SS_PRG1)
            ss_rdat = 8'(prg1);
        else if (ss_addr == SS_MISC)
            ss_rdat = {4'b0000, prg_swap, wram_en, mirror};
        else if (ss_is_chr)
            ss_rdat = ss_chr_hi ? ss_chr_wide[15:8] : ss_chr_wide[7:0];
        else if (ss_addr >= SS_LATCH && ss_addr <= SS_PRESC_HI)
            ss_rdat = tm_rdat;
    end

endmodule

// File: tb/tb_map_vrc4_core.sv
// Scoreboard bench for map_vrc4_core: stimulus queues expected values, a monitor
// on rising M2 (away from the falling active edge) pops and compares them.
module tb_map_vrc4_core;

    localparam int K_PRG   = 0;
    localparam int K_PRGF  = 1;
    localparam int K_CHR   = 2;
    localparam int K_CHRF  = 3;
    localparam int K_A10   = 4;
    localparam int K_RAMCE = 5;
    localparam int K_IRQ   = 6;
    localparam int K_SS    = 7;

    logic        m2;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic [13:0] ppu_addr;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;
    logic [7:0]  ss_rdat;
    logic [17:0] prg_addr;
    logic [18:0] chr_addr;
    logic        ciram_a10;
    logic        ram_ce;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    map_vrc4_core dut (
        .m2        (m2),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_dat   (cpu_dat),
        .cpu_rw    (cpu_rw),
        .ppu_addr  (ppu_addr),
        .ss_act    (ss_act),
        .ss_we     (ss_we),
        .ss_addr   (ss_addr),
        .ss_rdat   (ss_rdat),
        .prg_addr  (prg_addr),
        .chr_addr  (chr_addr),
        .ciram_a10 (ciram_a10),
        .ram_ce    (ram_ce),
        .irq       (irq)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_PRG:   return 32'(prg_addr[17:13]);
            K_PRGF:  return 32'(prg_addr);
            K_CHR:   return 32'(chr_addr[18:10]);
            K_CHRF:  return 32'(chr_addr);
            K_A10:   return 32'(ciram_a10);
            K_RAMCE: return 32'(ram_ce);
            K_IRQ:   return 32'(irq);
            K_SS:    return 32'(ss_rdat);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drains every queued expectation at each rising M2.
    always @(posedge m2) begin
        while (kind_q.size() != 0) begin
            int          k;
            logic [31:0] e;
            logic [31:0] a;
            string       n;
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = actual(k);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", n, a, e);
            end
        end
    end

    function automatic logic [7:0] ssv(input int i);
        return 8'((i * 37 + 11) % 256);
    endfunction

    function automatic logic [7:0] ss_mask(input int i);
        if (i <= 1)                return 8'h1F;
        if (i == 2)                return 8'h0F;
        if (i >= 3 && i <= 10)     return 8'hFF;
        if (i >= 11 && i <= 18)    return 8'h01;
        if (i == 21)               return 8'h07;
        if (i == 23)               return 8'h03;
        return 8'hFF;
    endfunction

    task automatic expect_v(input int k, input logic [31:0] e, input string n);
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic sync();
        int n;
        n = 0;
        while (kind_q.size() != 0 && n < 40) begin
            #1;
            n++;
        end
        if (kind_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL sync_timeout: got %0d pending, expected 0", kind_q.size());
            kind_q.delete();
            exp_q.delete();
            name_q.delete();
        end
        #2;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dat  = d;
        cpu_rw   = 1'b0;
        @(negedge m2);
        #1;
        cpu_rw   = 1'b1;
        cpu_addr = 16'h0000;
    endtask

    task automatic chk_prg(input logic [15:0] a, input logic [31:0] e, input string n);
        cpu_addr = a;
        expect_v(K_PRG, e, n);
        sync();
    endtask

    task automatic chk_ppu(input int k, input logic [13:0] p, input logic [31:0] e, input string n);
        ppu_addr = p;
        expect_v(k, e, n);
        sync();
    endtask

    task automatic chk_ss(input logic [7:0] idx, input logic [31:0] e, input string n);
        ss_addr = idx;
        expect_v(K_SS, e, n);
        sync();
    endtask

    initial begin
        rst_n    = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dat  = 8'h00;
        cpu_rw   = 1'b1;
        ppu_addr = 14'h0000;
        ss_act   = 1'b0;
        ss_we    = 1'b0;
        ss_addr  = 8'd0;
        repeat (3) @(negedge m2);
        #1 rst_n = 1'b1;

        // Reset state
        chk_prg(16'hE000, 31, "rst_prg_e000");
        chk_prg(16'h8000, 0, "rst_prg_8000");
        chk_prg(16'hC000, 30, "rst_prg_c000");
        expect_v(K_IRQ, 0, "rst_irq");
        sync();
        chk_ppu(K_A10, 14'h0400, 1, "rst_a10_v1");
        chk_ppu(K_A10, 14'h0800, 0, "rst_a10_v0");
        chk_ss(8'd22, 8'h55, "rst_presc_lo");
        chk_ss(8'd23, 8'h01, "rst_presc_hi");
        cpu_addr = 16'h6000;
        expect_v(K_RAMCE, 0, "rst_ramce");
        sync();

        // PRG banking and swap
        cpu_write(16'h8000, 8'h05);
        cpu_write(16'h9002, 8'h02);
        chk_prg(16'hC000, 5, "swap_c000");
        chk_prg(16'h8000, 30, "swap_8000");
        chk_prg(16'hA000, 0, "swap_a000");
        chk_prg(16'hE000, 31, "swap_e000");
        cpu_write(16'hA002, 8'h09);
        cpu_write(16'h9002, 8'h01);
        chk_prg(16'h8000, 5, "noswap_8000");
        chk_prg(16'hA000, 9, "prg1_a000");
        chk_prg(16'hC000, 30, "noswap_c000");
        cpu_addr = 16'hE123;
        expect_v(K_PRGF, 32'h3E123, "prg_full_e123");
        sync();
        cpu_addr = 16'h6000;
        expect_v(K_RAMCE, 1, "ramce_6000");
        sync();
        cpu_addr = 16'h8000;
        expect_v(K_RAMCE, 0, "ramce_8000");
        sync();

        // Mirroring
        cpu_write(16'h9000, 8'h01);
        chk_ppu(K_A10, 14'h0800, 1, "mir_h_1");
        chk_ppu(K_A10, 14'h0400, 0, "mir_h_0");
        cpu_write(16'h9000, 8'h03);
        chk_ppu(K_A10, 14'h0000, 1, "mir_s1");
        cpu_write(16'h9000, 8'h02);
        chk_ppu(K_A10, 14'h0C00, 0, "mir_s0");

        // CHR slots
        cpu_write(16'hB000, 8'h07);
        cpu_write(16'hB001, 8'h1F);
        chk_ppu(K_CHR, 14'h0000, 32'h1F7, "chr0_1f7");
        chk_ppu(K_CHRF, 14'h0123, 32'h7DD23, "chr0_full");
        cpu_write(16'hB002, 8'h03);
        chk_ppu(K_CHR, 14'h0400, 32'h003, "chr1_003");
        chk_ppu(K_CHR, 14'h0000, 32'h1F7, "chr0_keep");
        cpu_write(16'hE002, 8'h05);
        cpu_write(16'hE003, 8'h0A);
        chk_ppu(K_CHR, 14'h1C00, 32'h0A5, "chr7_0a5");

        // Cycle-mode IRQ
        cpu_write(16'hF000, 8'h0D);
        cpu_write(16'hF001, 8'h0F);
        ss_addr = 8'd20;
        cpu_write(16'hF002, 8'h06);
        expect_v(K_IRQ, 0, "cyc_irq_w");
        expect_v(K_SS, 8'hFD, "cyc_cnt_w");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 0, "cyc_irq_1");
        expect_v(K_SS, 8'hFE, "cyc_cnt_1");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 0, "cyc_irq_2");
        expect_v(K_SS, 8'hFF, "cyc_cnt_2");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 1, "cyc_irq_3");
        expect_v(K_SS, 8'hFD, "cyc_cnt_3");
        sync();
        cpu_write(16'hF003, 8'h00);
        expect_v(K_IRQ, 0, "cyc_ack_irq");
        expect_v(K_SS, 8'hFE, "cyc_ack_cnt");
        sync();
        repeat (3) @(negedge m2);
        #1;
        expect_v(K_IRQ, 0, "cyc_stop_irq");
        expect_v(K_SS, 8'hFE, "cyc_stop_cnt");
        sync();

        // Same-edge interactions
        cpu_write(16'hF001, 8'h0F);
        cpu_write(16'hF000, 8'h0F);
        cpu_write(16'hF002, 8'h07);
        cpu_write(16'hF003, 8'h00);
        expect_v(K_IRQ, 1, "ack_vs_ovf_irq");
        expect_v(K_SS, 8'hFF, "ack_vs_ovf_cnt");
        sync();
        cpu_write(16'hF002, 8'h07);
        expect_v(K_IRQ, 0, "ctrl_vs_tick_irq");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 1, "reovf_irq");
        sync();
        cpu_write(16'hF000, 8'h00);
        expect_v(K_SS, 8'hFF, "latch_vs_ovf_cnt");
        sync();
        chk_ss(8'd19, 8'hF0, "latch_vs_ovf_latch");
        cpu_write(16'hF002, 8'h00);
        expect_v(K_IRQ, 0, "stop_irq");
        sync();

        // Scanline-mode IRQ through the prescaler
        cpu_write(16'hF000, 8'h0F);
        ss_addr = 8'd22;
        cpu_write(16'hF002, 8'h03);
        repeat (113) @(negedge m2);
        #1;
        expect_v(K_IRQ, 0, "sl1_pre_irq");
        expect_v(K_SS, 8'h02, "sl1_pre_presc");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 1, "sl1_irq");
        expect_v(K_SS, 8'h54, "sl1_presc");
        sync();
        cpu_write(16'hF003, 8'h01);
        expect_v(K_IRQ, 0, "sl1_ack");
        expect_v(K_SS, 8'h51, "sl1_ack_presc");
        sync();
        repeat (112) @(negedge m2);
        #1;
        expect_v(K_IRQ, 0, "sl2_pre_irq");
        expect_v(K_SS, 8'h01, "sl2_pre_presc");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 1, "sl2_irq");
        expect_v(K_SS, 8'h53, "sl2_presc");
        sync();
        cpu_write(16'hF003, 8'h01);
        expect_v(K_SS, 8'h50, "sl2_ack_presc");
        sync();
        repeat (111) @(negedge m2);
        #1;
        expect_v(K_IRQ, 0, "sl3_pre_irq");
        expect_v(K_SS, 8'h03, "sl3_pre_presc");
        sync();
        @(negedge m2); #1;
        expect_v(K_IRQ, 1, "sl3_irq");
        expect_v(K_SS, 8'h55, "sl3_presc");
        sync();
        cpu_write(16'hF002, 8'h00);

        // Save-state write and readback
        ss_act = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ss_addr = 8'(i);
            cpu_dat = ssv(i);
            ss_we   = 1'b1;
            @(negedge m2);
            #1;
        end
        ss_we = 1'b0;
        for (int i = 0; i < 24; i++)
            chk_ss(8'(i), 32'(ssv(i) & ss_mask(i)), $sformatf("ss_idx%0d", i));
        chk_ss(8'd24, 8'hFF, "ss_unused24");
        chk_ss(8'd255, 8'hFF, "ss_unused255");
        expect_v(K_IRQ, 1, "ss_irq");
        sync();
        chk_ppu(K_CHR, 14'h0000, 32'h07A, "ss_chr0_out");
        chk_prg(16'h8000, 11, "ss_prg0_out");

        // CPU writes are ignored while save-state access is active
        cpu_write(16'h8000, 8'h1F);
        cpu_write(16'h9000, 8'h03);
        cpu_write(16'hB000, 8'h0F);
        cpu_write(16'hF000, 8'h03);
        cpu_write(16'hF002, 8'h07);
        chk_ss(8'd0, 32'(ssv(0) & 8'h1F), "blk_prg0");
        chk_ss(8'd2, 32'(ssv(2) & 8'h0F), "blk_misc");
        chk_ss(8'd3, 32'(ssv(3)), "blk_chr0");
        chk_ss(8'd19, 32'(ssv(19)), "blk_latch");
        chk_ss(8'd21, 32'(ssv(21) & 8'h07), "blk_ctrl");
        expect_v(K_IRQ, 1, "blk_irq");
        sync();

        // Reset while counting with irq pending
        ss_act = 1'b0;
        cpu_write(16'hF000, 8'h0F);
        cpu_write(16'hF001, 8'h0F);
        cpu_write(16'hF002, 8'h06);
        @(negedge m2); #1;
        expect_v(K_IRQ, 1, "pre_rst_irq");
        sync();
        rst_n = 1'b0;
        #1;
        ss_addr = 8'd20;
        expect_v(K_IRQ, 0, "midrst_irq");
        expect_v(K_SS, 8'h00, "midrst_cnt");
        sync();
        chk_ss(8'd21, 8'h00, "midrst_ctrl");
        chk_ss(8'd23, 8'h01, "midrst_presc_hi");
        chk_prg(16'h8000, 0, "midrst_prg0");
        chk_ppu(K_A10, 14'h0400, 1, "midrst_a10");
        rst_n = 1'b1;
        @(negedge m2); #1;
        expect_v(K_IRQ, 0, "post_rst_irq");
        sync();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
